dcache_controller: RTL and testbench
====================================

# dcache_controller

Sequencing controller for the direct-mapped L1 data cache. It owns the 32-entry×24-bit tag SRAM and the matching 32-entry×256-bit data SRAM, and serves one CPU load/store port with hit/miss detection. On a miss it writes back dirty victims and refills lines over a req/ack handshake to data memory. It sits between the CPU MEM stage and the off-chip data memory model.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width (32 bytes); offset = addr[4:0], word select = addr[4:2]
- INDEX_W, 5, set index = addr[9:5]
- TAG_W, 22, tag = addr[31:10]

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- p1_req_i  in  1  CPU access request, held until stall_o low
- p1_write_i  in  1  1 = store, 0 = load
- p1_addr_i  in  32  byte address (word-aligned)
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data, valid when p1_req_i & ~p1_stall_o
- p1_stall_o  out  1  CPU must hold request
- tag_addr_o / tag_enable_o / tag_write_o / tag_data_o  out  5/1/1/24  tag SRAM port
- tag_data_i  in  24  tag SRAM read data: [23]=valid, [22]=dirty, [21:0]=tag
- data_addr_o / data_enable_o / data_write_o / data_data_o  out  5/1/1/256  data SRAM port
- data_data_i  in  256  data SRAM read line
- mem_enable_o  out  1  memory request, held until mem_ack_i
- mem_write_o  out  1  1 = write-back, 0 = fill
- mem_addr_o  out  32  line address, [4:0]=0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fill line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- Both SRAMs read combinationally (enable gated) and write on the rising edge. tag/data addr = p1_addr_i[9:5] except in INIT.
- hit = tag_data_i[23] & (tag_data_i[21:0] == p1_addr_i[31:10]).
- States: INIT, IDLE, WRITEBACK, ALLOCATE, REFILL.
- INIT: after reset, 32 cycles writing 24'b0 to tag entries 0..31 via a 5-bit counter. Last write at count 31, then IDLE. Data SRAM is untouched.
- IDLE with p1_req_i:
  - Load hit: p1_data_o = data_data_i word [addr[4:2]].
  - Store hit: write the merged line (selected word replaced) to data SRAM, and write the tag with dirty=1, same edge.
  - Miss with victim valid&dirty: go to WRITEBACK. Miss otherwise: go to ALLOCATE.
- WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=data_data_i. On mem_ack_i go to ALLOCATE.
- ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={addr[31:5],5'b0}. On mem_ack_i, latch mem_data_i and go to REFILL.
- REFILL: write the latched line to data SRAM and {1,0,tag} to the tag SRAM, then IDLE. The request re-evaluates as a hit.
- p1_stall_o = p1_req_i & ~(state==IDLE & hit). It is also forced high in INIT.
- CPU address/data must stay stable while stalled. The controller does not latch them except the fill line.

## Timing
- Reset values:
  - state=INIT, counter=0.
  - Outputs: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p1_data_o=0, tag/data write=0.
- Hit latency: 0 stall cycles.
- Clean miss: 1 (detect) + ALLOCATE cycles through ack + 1 REFILL. The hit completes in the following IDLE cycle.
- Dirty miss adds WRITEBACK cycles through its ack.
- mem_enable_o drops in the cycle after mem_ack_i. Never two requests back-to-back without a state change.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Reset mid-transfer: immediate return to INIT, mem_enable_o=0. The outstanding memory op is abandoned.
- p1_req_i low in IDLE: no SRAM writes, stall_o=0.

## Structure
- Package dcache_pkg holds:
  - constants ADDR_W, LINE_W, TAG_W, INDEX_W, OFFSET_W, and tag field bit positions (VALID_BIT=23, DIRTY_BIT=22)
  - the state enum
- No sub-module. The SRAMs are instantiated beside this block at cache top level, not inside it.

## Test plan
- Reset, hold p1_req_i=1 -> stall high for exactly 32 cycles of INIT. All 32 tag entries read 24'h000000 afterwards.
- Load 0x0000_0404 (cold), memory acks after 3 cycles with line word1=0xDEADBEEF -> one fill request at 0x400, then p1_data_o=0xDEADBEEF. Tag[0] = valid, tag=1.
- Store 0xCAFE0001 to 0x0000_0408 after that fill -> no memory request, 0 stall. Tag entry dirty=1, and a load from 0x408 returns 0xCAFE0001.
- Load 0x0000_0800 (same index 0, different tag) with the line dirty -> write-back to 0x400 with the modified line, then fill from 0x800. Tag is clean, tag=2.
- Assert rst_i low during ALLOCATE -> mem_enable_o=0 immediately, INIT re-runs, and the next access misses.
- Delay ack 20 cycles with p1_req_i held -> mem_enable_o, mem_addr_o and p1_stall_o stay constant throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, tag field layout and controller states for the L1 data cache
package dcache_pkg;
  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 256;
  localparam int TAG_W     = 22;
  localparam int INDEX_W   = 5;
  localparam int OFFSET_W  = 5;
  localparam int VALID_BIT = 23;
  localparam int DIRTY_BIT = 22;
  localparam int TAGE_W    = TAG_W + 2;
  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_REFILL    = 3'd4
  } state_t;
endpackage

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back L1 data cache sequencer (tag clear, hit/miss, write-back, refill)
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                p1_req_i,
  input  logic                p1_write_i,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [31:0]         p1_data_i,
  output logic [31:0]         p1_data_o,
  output logic                p1_stall_o,
  output logic [INDEX_W-1:0]  tag_addr_o,
  output logic                tag_enable_o,
  output logic                tag_write_o,
  output logic [TAGE_W-1:0]   tag_data_o,
  input  logic [TAGE_W-1:0]   tag_data_i,
  output logic [INDEX_W-1:0]  data_addr_o,
  output logic                data_enable_o,
  output logic                data_write_o,
  output logic [LINE_W-1:0]   data_data_o,
  input  logic [LINE_W-1:0]   data_data_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
);
  state_t state, state_nx;
  logic [INDEX_W-1:0] cnt;
  logic [LINE_W-1:0]  fill_q, merged;
  logic [TAG_W-1:0]   tag_in;
  logic [INDEX_W-1:0] idx;
  logic [7:0]         sel;
  logic hit, init, idle, wb, alloc, refill, store_hit, unused;

  assign unused = &{1'b0, p1_addr_i[1:0]};
  assign tag_in = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign idx    = p1_addr_i[OFFSET_W +: INDEX_W];
  assign sel    = {p1_addr_i[4:2], 5'd0};
  assign init   = state == ST_INIT;
  assign idle   = state == ST_IDLE;
  assign wb     = state == ST_WRITEBACK;
  assign alloc  = state == ST_ALLOCATE;
  assign refill = state == ST_REFILL;
  assign hit    = tag_data_i[VALID_BIT] & (tag_data_i[TAG_W-1:0] == tag_in);
  assign store_hit = idle & p1_req_i & p1_write_i & hit;

  // Store data merged into the currently read line at the addressed word
  always_comb begin
    merged = data_data_i;
    merged[sel +: 32] = p1_data_i;
  end

  // Next-state selection; the victim's dirty bit decides whether a write-back precedes the fill
  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:      state_nx = &cnt ? ST_IDLE : ST_INIT;
      ST_IDLE:      state_nx = (p1_req_i & ~hit) ? ((tag_data_i[VALID_BIT] & tag_data_i[DIRTY_BIT]) ? ST_WRITEBACK : ST_ALLOCATE) : ST_IDLE;
      ST_WRITEBACK: state_nx = mem_ack_i ? ST_ALLOCATE : ST_WRITEBACK;
      ST_ALLOCATE:  state_nx = mem_ack_i ? ST_REFILL : ST_ALLOCATE;
      ST_REFILL:    state_nx = ST_IDLE;
      default:      state_nx = ST_INIT;
    endcase
  end

  // State, tag-clear counter and the captured fill line
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_INIT;
      cnt    <= '0;
      fill_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= init ? cnt + 1'b1 : '0;
      if (alloc & mem_ack_i) fill_q <= mem_data_i;
    end
  end

  // CPU side: tag writes are suppressed while reset is held so the SRAM is untouched during reset
  assign p1_stall_o    = init | (p1_req_i & ~(idle & hit));
  assign p1_data_o     = (idle & p1_req_i & hit) ? data_data_i[sel +: 32] : 32'd0;
  assign tag_addr_o    = init ? cnt : idx;
  assign tag_enable_o  = init | ~idle | p1_req_i;
  assign tag_write_o   = (init & rst_i) | store_hit | refill;
  assign tag_data_o    = init ? '0 : {1'b1, store_hit, tag_in};
  assign data_addr_o   = idx;
  assign data_enable_o = ~init & (~idle | p1_req_i);
  assign data_write_o  = store_hit | refill;
  assign data_data_o   = refill ? fill_q : merged;
  assign mem_enable_o  = wb | alloc;
  assign mem_write_o   = wb;
  assign mem_addr_o    = wb ? {tag_data_i[TAG_W-1:0], idx, {OFFSET_W{1'b0}}} :
                         alloc ? {p1_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
  assign mem_data_o    = wb ? data_data_i : '0;
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed test of the data cache controller against a flat memory model
module tb_dcache_controller;
  logic clk = 0, rst_i = 0;
  logic p1_req_i = 0, p1_write_i = 0;
  logic [31:0] p1_addr_i = 0, p1_data_i = 0, p1_data_o;
  logic p1_stall_o;
  logic [4:0] tag_addr_o, data_addr_o;
  logic tag_enable_o, tag_write_o, data_enable_o, data_write_o;
  logic [23:0] tag_data_o, tag_data_i;
  logic [255:0] data_data_o, data_data_i, mem_data_o, mem_data_i;
  logic mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0] mem_addr_o;

  logic [23:0]  tag_mem [32] = '{default: 24'hFFFFFF};
  logic [255:0] dat_mem [32] = '{default: {256{1'b1}}};
  logic [255:0] bmem [int];
  logic [255:0] gold [int];
  logic [32:0]  reqs [$];
  int total = 0, bad = 0, ack_delay = 3, wc = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .tag_addr_o(tag_addr_o), .tag_enable_o(tag_enable_o), .tag_write_o(tag_write_o),
    .tag_data_o(tag_data_o), .tag_data_i(tag_data_i),
    .data_addr_o(data_addr_o), .data_enable_o(data_enable_o), .data_write_o(data_write_o),
    .data_data_o(data_data_o), .data_data_i(data_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  assign tag_data_i  = tag_enable_o ? tag_mem[tag_addr_o] : '0;
  assign data_data_i = data_enable_o ? dat_mem[data_addr_o] : '0;

  always @(posedge clk) begin
    if (tag_enable_o && tag_write_o) tag_mem[tag_addr_o] <= tag_data_o;
    if (data_enable_o && data_write_o) dat_mem[data_addr_o] <= data_data_o;
  end

  function automatic logic [255:0] dflt(int la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'(la * 8 + w) ^ 32'hA5A50000;
    return l;
  endfunction

  function automatic logic [255:0] gold_line(int la);
    return gold.exists(la) ? gold[la] : dflt(la);
  endfunction

  function automatic logic [255:0] bmem_line(int la);
    return bmem.exists(la) ? bmem[la] : dflt(la);
  endfunction

  task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Memory: acks each request after ack_delay cycles; write-backs must carry the CPU-visible line
  initial begin
    int la;
    mem_ack_i = 0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 0;
      if (rst_i && mem_enable_o) begin
        wc++;
        if (wc >= ack_delay) begin
          wc = 0;
          mem_ack_i = 1;
          la = int'(mem_addr_o >> 5);
          reqs.push_back({mem_write_o, mem_addr_o});
          if (mem_write_o) begin
            chk("wb_line", mem_data_o, gold_line(la));
            bmem[la] = mem_data_o;
          end else mem_data_i = bmem_line(la);
        end
      end else wc = 0;
    end
  end

  // Cache must be transparent: every completed load equals the flat memory model
  initial begin
    int la;
    logic [255:0] line;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        if (p1_req_i && !p1_stall_o) begin
          la = int'(p1_addr_i >> 5);
          line = gold_line(la);
          if (p1_write_i) begin
            line[{p1_addr_i[4:2], 5'd0} +: 32] = p1_data_i;
            gold[la] = line;
          end else chk("load_data", p1_data_o, line[{p1_addr_i[4:2], 5'd0} +: 32]);
        end
        if (mem_enable_o) begin
          chk("mem_align", mem_addr_o[4:0], 0);
          if (!mem_write_o) chk("fill_addr", mem_addr_o, {p1_addr_i[31:5], 5'd0});
        end
      end
    end
  end

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rd);
    @(posedge clk); #1;
    p1_req_i = 1; p1_write_i = w; p1_addr_i = a; p1_data_i = d;
    cyc = 0;
    @(negedge clk);
    while (p1_stall_o && cyc < 300) begin cyc++; @(negedge clk); end
    if (p1_stall_o) chk("access_timeout", 1, 0);
    rd = p1_data_o;
    @(posedge clk); #1;
    p1_req_i = 0; p1_write_i = 0;
  endtask

  initial begin
    int cyc, n, changes;
    logic [31:0] rd, a0;
    logic [255:0] l;
    l = dflt(32);
    l[63:32] = 32'hDEADBEEF;
    bmem[32] = l;
    gold[32] = l;
    repeat (3) @(posedge clk);
    #1 rst_i = 1;
    n = 0;
    @(negedge clk);
    while (p1_stall_o && n < 100) begin n++; @(negedge clk); end
    chk("init_len", n, 32);
    for (int i = 0; i < 32; i++) chk("tag_cleared", tag_mem[i], 0);

    access(0, 32'h0000_0404, 0, cyc, rd);
    chk("cold_cycles", cyc, 5);
    chk("cold_data", rd, 32'hDEADBEEF);
    chk("cold_nreq", reqs.size(), 1);
    chk("cold_req", reqs[0], {1'b0, 32'h400});
    chk("cold_tag", tag_mem[0], 24'h800001);

    access(1, 32'h0000_0408, 32'hCAFE0001, cyc, rd);
    chk("store_cycles", cyc, 0);
    chk("store_nreq", reqs.size(), 1);
    chk("store_tag", tag_mem[0], 24'hC00001);
    access(0, 32'h0000_0408, 0, cyc, rd);
    chk("reload_cycles", cyc, 0);
    chk("reload_data", rd, 32'hCAFE0001);

    access(0, 32'h0000_0800, 0, cyc, rd);
    chk("dirty_cycles", cyc, 8);
    chk("dirty_nreq", reqs.size(), 3);
    chk("dirty_wb_req", reqs[1], {1'b1, 32'h400});
    chk("dirty_fill_req", reqs[2], {1'b0, 32'h800});
    chk("dirty_data", rd, 32'hA5A50200);
    chk("dirty_tag", tag_mem[0], 24'h800002);
    l = bmem_line(32);
    chk("wb_word1", l[63:32], 32'hDEADBEEF);
    chk("wb_word2", l[95:64], 32'hCAFE0001);

    ack_delay = 20;
    @(posedge clk); #1;
    p1_req_i = 1; p1_addr_i = 32'h0000_1404;
    n = 0;
    @(negedge clk);
    while (!mem_enable_o && n < 10) begin n++; @(negedge clk); end
    chk("slow_started", mem_enable_o, 1);
    a0 = mem_addr_o;
    changes = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (mem_enable_o !== 1 || mem_addr_o !== a0 || p1_stall_o !== 1) changes++;
    end
    chk("slow_stable", changes, 0);
    chk("slow_addr", a0, 32'h1400);
    n = 0;
    while (p1_stall_o && n < 10) begin n++; @(negedge clk); end
    chk("slow_done", p1_stall_o, 0);
    @(posedge clk); #1 p1_req_i = 0;

    ack_delay = 50;
    @(posedge clk); #1;
    p1_req_i = 1; p1_addr_i = 32'h0000_1000;
    n = 0;
    @(negedge clk);
    while (!mem_enable_o && n < 10) begin n++; @(negedge clk); end
    chk("abort_started", mem_enable_o, 1);
    @(posedge clk); #2 rst_i = 0;
    #1;
    chk("abort_mem_en", mem_enable_o, 0);
    chk("abort_stall", p1_stall_o, 1);
    chk("abort_tag_wr", tag_write_o, 0);
    ack_delay = 3;
    n = reqs.size();
    @(posedge clk); #1 rst_i = 1;
    cyc = 0;
    @(negedge clk);
    while (p1_stall_o && cyc < 300) begin cyc++; @(negedge clk); end
    chk("reinit_cycles", cyc, 37);
    chk("reinit_nreq", reqs.size(), n + 1);
    chk("reinit_req", reqs[reqs.size() - 1], {1'b0, 32'h1000});
    @(posedge clk); #1 p1_req_i = 0;
    chk("reinit_tag", tag_mem[0], 24'h800004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
